// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame-length limits and parity-select codes.
// Used by both the receive and transmit halves.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StDone
    } uart_state_e;

    localparam int unsigned F_MIN = 8;
    localparam int unsigned F_MAX = 10;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bits after the start bit: data (7/8), optional parity, stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-time down-counter. Loads K or K>>1 and pulses done once per load interval.
module uart_bit_timer #(
    parameter int unsigned CW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          half,
    input  logic [CW-1:0] k,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = half ? (k >> 1) : k;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle the count reaches zero at the next edge, so a load of L
    // spaces consecutive acting edges exactly L clocks apart.
    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronises RX, finds start bits, samples mid-bit and deserialises
// 7/8 data bits with optional parity, reporting parity, framing and overrun status.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CW   = 20,
    parameter int unsigned SYNC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RX,
    input  logic [CW-1:0] K,
    input  logic          EIGHT,
    input  logic          PEN,
    input  logic          OHEL,
    input  logic          READ,
    output logic [7:0]    RX_DATA,
    output logic          RXRDY,
    output logic          PERR,
    output logic          FERR,
    output logic          OVF
);

    logic [SYNC-1:0] sync_q;
    logic            rxs;

    uart_state_e state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  shreg_q, shreg_d;
    logic        eight_q, pen_q, ohel_q;
    logic [CW-1:0] k_q;
    logic        cfg_capture;

    logic          tmr_load, tmr_half, tmr_done;
    logic [CW-1:0] tmr_k;

    logic [3:0] flen;
    logic [9:0] frame;
    logic [7:0] data_new;
    logic       par_bit, stop_bit, par_exp, perr_new;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], RX};
        end
    end

    assign rxs = sync_q[SYNC-1];

    // The start-detect load must use the live K since k_q is only captured on that edge.
    assign tmr_k = cfg_capture ? K : k_q;

    uart_bit_timer #(
        .CW(CW)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .load (tmr_load),
        .half (tmr_half),
        .k    (tmr_k),
        .done (tmr_done)
    );

    assign flen = frame_len(eight_q, pen_q);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        tmr_load    = 1'b0;
        tmr_half    = 1'b0;
        cfg_capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d     = StStart;
                    tmr_load    = 1'b1;
                    tmr_half    = 1'b1;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                    cfg_capture = 1'b1;
                end
            end
            StStart: begin
                if (tmr_done) begin
                    if (rxs) begin
                        state_d = StIdle;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = StData;
                    end
                end
            end
            StData: begin
                if (tmr_done) begin
                    shreg_d   = {rxs, shreg_q[9:1]};
                    tmr_load  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_d == flen) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bits enter at the MSB end, so a short frame sits high and is shifted down.
    assign frame    = shreg_q >> (4'd10 - flen);
    assign data_new = {eight_q & frame[7], frame[6:0]};
    assign par_bit  = eight_q ? frame[8] : frame[7];
    assign stop_bit = frame[flen - 4'd1];
    assign par_exp  = (ohel_q == PAR_EVEN) ? ^data_new : ~^data_new;
    assign perr_new = pen_q & (par_bit != par_exp);

    always_comb begin
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        if (state_q == StDone) begin
            rx_data_d = data_new;
            perr_d    = perr_new;
            ferr_d    = ~stop_bit;
            rxrdy_d   = 1'b1;
            ovf_d     = ovf_q | (rxrdy_q & ~READ);
        end else if (READ && rxrdy_q) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            k_q       <= '0;
            rx_data_q <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            if (cfg_capture) begin
                eight_q <= EIGHT;
                pen_q   <= PEN;
                ohel_q  <= OHEL;
                k_q     <= K;
            end
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign RX_DATA = rx_data_q;
    assign RXRDY   = rxrdy_q;
    assign PERR    = perr_q;
    assign FERR    = ferr_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: framing variants, parity, framing error, overrun,
// glitch rejection, latency and asynchronous reset mid-frame.
module tb_uart_rx_engine;

    localparam int unsigned CW   = 20;
    localparam int unsigned SYNC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          RX;
    logic [CW-1:0] K;
    logic          EIGHT, PEN, OHEL, READ;
    logic [7:0]    RX_DATA;
    logic          RXRDY, PERR, FERR, OVF;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc = -1;
    logic rdy_prev = 1'b0;

    uart_rx_engine #(
        .CW  (CW),
        .SYNC(SYNC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .RX     (RX),
        .K      (K),
        .EIGHT  (EIGHT),
        .PEN    (PEN),
        .OHEL   (OHEL),
        .READ   (READ),
        .RX_DATA(RX_DATA),
        .RXRDY  (RXRDY),
        .PERR   (PERR),
        .FERR   (FERR),
        .OVF    (OVF)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle on which RXRDY first rises.
    always @(posedge clk) begin
        #1;
        if (RXRDY && !rdy_prev) rise_cyc = cyc;
        rdy_prev = RXRDY;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, then payload[0..nbits-1] LSB first, each held K clocks; line left idle.
    task automatic send_frame(input logic [9:0] payload, input int nbits);
        @(posedge clk);
        #1;
        RX       = 1'b0;
        fall_cyc = cyc;
        rise_cyc = -1;
        repeat (int'(K)) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            #1 RX = payload[i];
            repeat (int'(K)) @(posedge clk);
        end
        #1 RX = 1'b1;
    endtask

    task automatic pulse_read();
        @(posedge clk);
        #1 READ = 1'b1;
        @(posedge clk);
        #1 READ = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        RX    = 1'b1;
        K     = CW'(16);
        EIGHT = 1'b1;
        PEN   = 1'b0;
        OHEL  = 1'b0;
        READ  = 1'b0;
        idle(3);
        check_eq("rst_data", {24'b0, RX_DATA}, 32'h0);
        check_eq("rst_rdy", {31'b0, RXRDY}, 32'h0);
        check_eq("rst_perr", {31'b0, PERR}, 32'h0);
        check_eq("rst_ferr", {31'b0, FERR}, 32'h0);
        check_eq("rst_ovf", {31'b0, OVF}, 32'h0);
        reset = 1'b0;
        idle(5);

        // 8N1 0xA5 with latency
        send_frame({2'b11, 8'hA5}, 9);
        check_eq("a5_lat", rise_cyc - fall_cyc, 32'd156);
        check_eq("a5_data", {24'b0, RX_DATA}, 32'hA5);
        check_eq("a5_rdy", {31'b0, RXRDY}, 32'h1);
        check_eq("a5_perr", {31'b0, PERR}, 32'h0);
        check_eq("a5_ferr", {31'b0, FERR}, 32'h0);
        check_eq("a5_ovf", {31'b0, OVF}, 32'h0);
        pulse_read();
        check_eq("a5_rd_rdy", {31'b0, RXRDY}, 32'h0);
        check_eq("a5_rd_data", {24'b0, RX_DATA}, 32'hA5);

        // 7E1 0x55: good parity then bad parity
        EIGHT = 1'b0;
        PEN   = 1'b1;
        OHEL  = 1'b0;
        idle(4);
        send_frame({1'b1, 1'b1, 1'b0, 7'h55}, 9);
        check_eq("e55_data", {24'b0, RX_DATA}, 32'h55);
        check_eq("e55_perr", {31'b0, PERR}, 32'h0);
        check_eq("e55_ferr", {31'b0, FERR}, 32'h0);
        pulse_read();
        send_frame({1'b1, 1'b1, 1'b1, 7'h55}, 9);
        check_eq("e55b_data", {24'b0, RX_DATA}, 32'h55);
        check_eq("e55b_perr", {31'b0, PERR}, 32'h1);
        pulse_read();
        check_eq("e55b_rd_perr", {31'b0, PERR}, 32'h0);

        // 8O1 0x80: good parity, then stop bit 0
        EIGHT = 1'b1;
        PEN   = 1'b1;
        OHEL  = 1'b1;
        idle(4);
        send_frame({1'b1, 1'b0, 8'h80}, 10);
        check_eq("o80_data", {24'b0, RX_DATA}, 32'h80);
        check_eq("o80_perr", {31'b0, PERR}, 32'h0);
        check_eq("o80_ferr", {31'b0, FERR}, 32'h0);
        pulse_read();
        send_frame({1'b0, 1'b0, 8'h80}, 10);
        check_eq("f80_data", {24'b0, RX_DATA}, 32'h80);
        check_eq("f80_ferr", {31'b0, FERR}, 32'h1);
        check_eq("f80_perr", {31'b0, PERR}, 32'h0);
        idle(40);
        check_eq("f80_ovf", {31'b0, OVF}, 32'h0);
        pulse_read();
        check_eq("f80_rd_ferr", {31'b0, FERR}, 32'h0);

        // Overrun: two frames without READ
        EIGHT = 1'b1;
        PEN   = 1'b0;
        OHEL  = 1'b0;
        idle(4);
        send_frame({2'b11, 8'h11}, 9);
        send_frame({2'b11, 8'h22}, 9);
        check_eq("ov_data", {24'b0, RX_DATA}, 32'h22);
        check_eq("ov_ovf", {31'b0, OVF}, 32'h1);
        check_eq("ov_rdy", {31'b0, RXRDY}, 32'h1);
        pulse_read();
        check_eq("ov_rd_rdy", {31'b0, RXRDY}, 32'h0);
        check_eq("ov_rd_ovf", {31'b0, OVF}, 32'h0);
        check_eq("ov_rd_data", {24'b0, RX_DATA}, 32'h22);

        // 3-cycle glitch is rejected, then a valid frame
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (3) @(posedge clk);
        #1 RX = 1'b1;
        idle(40);
        check_eq("gl_rdy", {31'b0, RXRDY}, 32'h0);
        send_frame({2'b11, 8'h3C}, 9);
        check_eq("3c_lat", rise_cyc - fall_cyc, 32'd156);
        check_eq("3c_data", {24'b0, RX_DATA}, 32'h3C);
        check_eq("3c_flags", {29'b0, PERR, FERR, OVF}, 32'h0);

        // Reset mid-DATA of a 0xFF frame, RXRDY still held from 0x3C
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (16) @(posedge clk);
        #1 RX = 1'b1;
        repeat (48) @(posedge clk);
        #1;
        check_eq("pre_rst_rdy", {31'b0, RXRDY}, 32'h1);
        reset = 1'b1;
        #2;
        check_eq("mid_rst_data", {24'b0, RX_DATA}, 32'h0);
        check_eq("mid_rst_rdy", {31'b0, RXRDY}, 32'h0);
        check_eq("mid_rst_flags", {29'b0, PERR, FERR, OVF}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(10);
        send_frame({2'b11, 8'h0F}, 9);
        check_eq("0f_lat", rise_cyc - fall_cyc, 32'd156);
        check_eq("0f_data", {24'b0, RX_DATA}, 32'h0F);
        check_eq("0f_rdy", {31'b0, RXRDY}, 32'h1);
        check_eq("0f_flags", {29'b0, PERR, FERR, OVF}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Receive half of the full UART; the far end of the transmit shift-register framing set by EIGHT/PEN/OHEL.
- Detects start bits, samples each bit at mid-bit using the programmed bit-time divisor, and deserialises 7 or 8 data bits plus optional parity and stop.
- Presents the received byte with parity-error, framing-error and overrun flags to the CPU-side register interface.

Parameters:
- CW, 20, width of bit-time divisor K and internal bit-time counter.
- SYNC, 2, number of flops synchronising RX to clk (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- RX  input  1  serial line, idle high, asynchronous to clk
- K  input  CW  clocks per bit; legal range 4 .. 2^CW-1
- EIGHT  input  1  1 = 8 data bits, 0 = 7
- PEN  input  1  parity bit present
- OHEL  input  1  0 = even parity, 1 = odd parity
- READ  input  1  one-cycle pulse; CPU has consumed RX_DATA and flags
- RX_DATA  output  8  received byte; bit 7 forced 0 when EIGHT=0
- RXRDY  output  1  byte available
- PERR  output  1  parity error on the held byte
- FERR  output  1  stop bit sampled 0 on the held byte
- OVF  output  1  a frame completed while RXRDY was already 1

Behaviour:
- Reset (async): all outputs 0; FSM to IDLE; counters 0; synchroniser flops 1.
- RX passes through SYNC flops to give rxs; all decisions use rxs.
- Frame length after start: F = 8 + EIGHT + PEN bits (data, optional parity, stop).
- EIGHT/PEN/OHEL/K are captured into internal copies on the start-detect cycle. Changes mid-frame are ignored until the next frame.
- FSM IDLE:
  - rxs==0 -> START; bit-time counter loads K>>1; bit counter = 0.
- FSM START:
  - Counter decrements; at 0 sample rxs.
  - If 1 (glitch): -> IDLE, no flags touched.
  - If 0: counter loads K -> DATA.
- FSM DATA:
  - At each counter 0, shift rxs into a 10-bit shift register (LSB-first, entering at the MSB end); counter reloads K; bit counter ++.
  - When bit counter reaches F -> DONE.
- FSM DONE (one cycle):
  - Right-justify the captured bits.
  - d[6:0] = b0..b6; d[7] = EIGHT ? b7 : 0.
  - Parity bit p at index 7+EIGHT; stop bit s at index F-1.
  - Expected parity = even ? ^d : ~^d, over 7 or 8 data bits.
  - Next cycle: RX_DATA <= d; PERR <= PEN & (p != expected); FERR <= ~s; RXRDY <= 1; OVF <= OVF | (RXRDY & ~READ).
  - FSM -> IDLE. A new start is not accepted until IDLE, even if s==0.
- Latency: RXRDY rises exactly SYNC + 1 + K/2 + F*K + 1 cycles after the RX falling edge (K even).
- READ while RXRDY=1 and no completion that cycle: RXRDY, PERR, FERR, OVF cleared next cycle; RX_DATA holds.
- READ in the same cycle as a DONE load: new data and flags are loaded, RXRDY stays 1, OVF is not set by this frame.
- Overrun: RX_DATA, PERR and FERR are overwritten by the newer frame. OVF is sticky until READ.
- Break (RX held 0): FERR=1 and RX_DATA=0x00 for each frame. A new start is detected immediately after IDLE, so back-to-back FERR frames repeat until the line returns high.
- Bit-time counter arithmetic is CW-bit unsigned with no wrap: it reloads on 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding {IDLE, START, DATA, DONE}.
  - Frame-length constants (F_MIN=8, F_MAX=10).
  - Parity-select encodings, shared with the transmit-side decode.
- One natural sub-module, uart_bit_timer: loadable down-counter with K or K>>1 load and a done pulse. It is reused by the transmitter.
- Synchroniser stays inline.

Test Plan:
- K=16, EIGHT=1 PEN=0, send 0xA5 + stop 1 -> RX_DATA=0xA5, RXRDY=1 exactly 2+1+8+144+1=156 cycles after the falling edge; PERR=FERR=OVF=0.
- K=16, EIGHT=0 PEN=1 OHEL=0, send 7'h55 with parity 0 -> RX_DATA=0x55, PERR=0; repeat with parity 1 -> PERR=1.
- EIGHT=1 PEN=1 OHEL=1, send 0x80 with parity 0 -> PERR=0; send 0x80 with stop bit 0 -> FERR=1, RX_DATA=0x80.
- Two frames 0x11, 0x22 with no READ -> RX_DATA=0x22, OVF=1; READ pulse -> RXRDY=OVF=0, RX_DATA stays 0x22.
- RX low pulse of 3 cycles with K=16 -> no RXRDY, FSM back to IDLE; a later valid 0x3C frame is received correctly.
- Assert reset mid-DATA of a 0xFF frame -> all outputs 0 immediately; the next full frame 0x0F is received with no error flags.
